dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the xgriscv pipeline: the memory-side end of the MEM-stage load/store interface. It accepts one load or store request at a time and inserts a programmable number of wait states, during which the pipeline is stalled. It performs byte, halfword or word access with sign or zero extension on loads, flags misaligned accesses, and returns a one-cycle completion pulse. It replaces the zero-latency `dmem` when the team models multi-cycle memory.

## Interface
- `XLEN`, 32: data and address width.
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; must be a power of two.
- `LATENCY`, 2: wait-state count, legal range 0..7.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 1: request valid; held stable by the pipeline until `done`.
- `we` input 1: 1 = store, 0 = load (`memwriteM`).
- `addr` input XLEN: byte address (`aluoutM`).
- `wdata` input XLEN: store data.
- `lb`, `lh` input 1 each: byte or halfword load; neither set = word load.
- `sb`, `sh` input 1 each: byte or halfword store; neither set = word store.
- `lu` input 1: zero-extend the load result when 1; sign-extend when 0.
- `pc` input ADDR_SIZE: PC of the memory instruction, used for trace.
- `busy` output 1: combinational stall, `req & ~done`.
- `done` output 1: registered one-cycle completion pulse.
- `rdata` output XLEN: registered load result, valid while `done`=1.
- `err` output 1: misaligned-access flag, valid while `done`=1.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, when `req`=1:
  - capture `addr`, `wdata`, `we`, size/`lu` flags and `pc`;
  - load `cnt` = LATENCY;
  - go to WAIT, or straight to DONE if LATENCY = 0.
- WAIT:
  - while `cnt` ≠ 1, decrement `cnt`;
  - when `cnt` = 1, perform the access and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
  - A `req` still high in this cycle is ignored.
  - A new request is accepted from IDLE on the next cycle.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so accesses wrap modulo the memory size.
- Size priority: `lb` over `lh`; `sb` over `sh`.
- Loads:
  - byte: lane `addr[1:0]`;
  - half: lane `addr[1]`;
  - extend to XLEN per `lu`.
- Stores: write only the selected lanes; all other bytes of the word are unchanged.
- Misalignment rules:
  - a halfword access is misaligned when `addr[0]`=1;
  - a word access is misaligned when `addr[1:0]` ≠ 0.
- On a misaligned access:
  - `err`=1 with `done`;
  - no write occurs;
  - `rdata` = 0.
- Each committed store prints a trace line: pc, addr, data.
- Memory contents are not initialised or cleared by `reset`.

## Timing
- Reset values: `done`=0, `rdata`=0, `err`=0, state = IDLE, `cnt`=0.
  - `busy` follows `req` after reset, because `done`=0.
- Latency: `done` rises LATENCY+1 cycles after the edge that accepted `req`. With LATENCY=0 this is the next cycle.
- Store commit: memory is written on the clock edge entering DONE.
  - A load issued in a later request sees the new data.
- Back-to-back requests: minimum issue spacing is LATENCY+2 cycles.
- Reset mid-operation:
  - state returns to IDLE;
  - a pending store is dropped and memory is untouched;
  - `done` stays 0.
- `req` dropping during WAIT: not permitted by protocol. The block still completes the access.
- `rdata` and `err` hold their values after `done` until the next completion or `reset`.

## Test plan
- LATENCY=2, store word 0xDEADBEEF to 0x10, then load word 0x10 → `done` 3 cycles after each accept; `rdata`=0xDEADBEEF; `busy` high for 3 cycles per request.
- Byte loads from 0x10:
  - `lb` at 0x13 → 0xFFFFFFDE;
  - `lb`+`lu` at 0x13 → 0x000000DE;
  - `lh` at 0x12 → 0xFFFFDEAD.
- `sb` 0x55 at 0x11, then load word 0x10 → 0xDEAD55EF. Then `sh` 0x1234 at 0x12, load word → 0x123455EF.
- Misaligned accesses:
  - `lh` at 0x11 → `err`=1, `rdata`=0;
  - word store at 0x12 → `err`=1, memory unchanged on re-read.
- Wrap-around: word store to byte address 4*DEPTH_WORDS+8 lands at word 2 (read back from 0x8). LATENCY=0 run gives `done` exactly 1 cycle after accept.
- Reset asserted in WAIT of a store of 0xAAAAAAAA to 0x20 → `done` never pulses; a later load of 0x20 returns the old value; all outputs 0 after reset.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: memory-side responder for the MEM-stage load/store interface.
// It accepts one request at a time, stalls for LATENCY wait states and then
// completes the access with a one-cycle done pulse. It supports byte, halfword
// and word access, sign or zero extension on loads, and misalignment flagging.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   req                 : request valid, held by the pipeline until done
//   we                  : 1 = store, 0 = load
//   addr, wdata         : byte address and store data
//   lb, lh / sb, sh     : load / store size (byte over half; neither = word)
//   lu                  : zero-extend the load result
//   pc                  : PC of the memory instruction (trace only)
//   busy                : combinational stall, req & ~done
//   done                : registered one-cycle completion pulse
//   rdata, err          : load result and misaligned flag, valid with done
//   dbg_state           : current FSM state (IDLE=0, WAIT=1, DONE=2)
//   trace_valid         : high with done when a store actually wrote memory
//   trace_pc/addr/data  : pc, address and full written word of that store
//
// Handshake: the pipeline raises req with stable operands and keeps it high
// until it sees done=1; a req still high during the done cycle is ignored and
// the next request is accepted from IDLE one cycle later.
module dmem_resp #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_SIZE   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      wdata,
  input  logic                 lb,
  input  logic                 lh,
  input  logic                 sb,
  input  logic                 sh,
  input  logic                 lu,
  input  logic [ADDR_SIZE-1:0] pc,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      rdata,
  output logic                 err,
  output logic [1:0]           dbg_state,
  output logic                 trace_valid,
  output logic [ADDR_SIZE-1:0] trace_pc,
  output logic [XLEN-1:0]      trace_addr,
  output logic [XLEN-1:0]      trace_data
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT   = 3'(LATENCY);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  lb_q, lb_d, lh_q, lh_d, sb_q, sb_d, sh_q, sh_d, lu_q, lu_d;
  logic [ADDR_SIZE-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;

  logic [XLEN-1:0]       mem [DEPTH_WORDS];

  // Operands of the access: live inputs when the access happens on the
  // accepting edge (LATENCY=0), captured copies otherwise.
  logic                  in_idle;
  logic [XLEN-1:0]       cur_addr, cur_wdata;
  logic                  cur_we, cur_lb, cur_lh, cur_sb, cur_sh, cur_lu;
  logic [IDX_W-1:0]      cur_idx;

  logic                  size_b, size_h, misal, go, mem_we;
  logic [XLEN-1:0]       rd_word, load_val, wr_word;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  always_comb begin
    in_idle   = (state_q == S_IDLE);
    cur_addr  = in_idle ? addr  : addr_q;
    cur_wdata = in_idle ? wdata : wdata_q;
    cur_we    = in_idle ? we    : we_q;
    cur_lb    = in_idle ? lb    : lb_q;
    cur_lh    = in_idle ? lh    : lh_q;
    cur_sb    = in_idle ? sb    : sb_q;
    cur_sh    = in_idle ? sh    : sh_q;
    cur_lu    = in_idle ? lu    : lu_q;
    cur_idx   = cur_addr[IDX_W+1:2];
  end

  // Access datapath: size decode, misalignment, load extraction, store merge.
  always_comb begin
    size_b   = cur_we ? cur_sb : cur_lb;
    size_h   = ~size_b & (cur_we ? cur_sh : cur_lh);
    if (size_b)      misal = 1'b0;
    else if (size_h) misal = cur_addr[0];
    else             misal = (cur_addr[1:0] != 2'b00);

    rd_word  = mem[cur_idx];
    byte_v   = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    half_v   = rd_word[{cur_addr[1], 4'b0000} +: 16];
    if (size_b)      load_val = {{(XLEN-8){~cur_lu & byte_v[7]}}, byte_v};
    else if (size_h) load_val = {{(XLEN-16){~cur_lu & half_v[15]}}, half_v};
    else             load_val = rd_word;

    wr_word = rd_word;
    if (size_b)      wr_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
    else if (size_h) wr_word[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
    else             wr_word = cur_wdata;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    lb_d      = lb_q;
    lh_d      = lh_q;
    sb_d      = sb_q;
    sh_d      = sh_q;
    lu_d      = lu_q;
    pc_d      = pc_q;
    wr_data_d = wr_data_q;
    go        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = we;
          lb_d    = lb;
          lh_d    = lh;
          sb_d    = sb;
          sh_d    = sh;
          lu_d    = lu;
          pc_d    = pc;
          if (LAT == 3'd0) begin
            go      = 1'b1;
            cnt_d   = 3'd0;
            state_d = S_DONE;
          end else begin
            cnt_d   = LAT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The access happens on the last wait edge, so done follows LATENCY
        // edges after the accepting one.
        if (cnt_q == 3'd1) begin
          go      = 1'b1;
          cnt_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (go) begin
      done_d    = 1'b1;
      err_d     = misal;
      rdata_d   = (cur_we | misal) ? '0 : load_val;
      wr_data_d = wr_word;
    end
  end

  // A reset on the commit edge drops the pending store.
  assign mem_we = go & cur_we & ~misal & ~reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      lb_q      <= 1'b0;
      lh_q      <= 1'b0;
      sb_q      <= 1'b0;
      sh_q      <= 1'b0;
      lu_q      <= 1'b0;
      pc_q      <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      lb_q      <= lb_d;
      lh_q      <= lh_d;
      sb_q      <= sb_d;
      sh_q      <= sh_d;
      lu_q      <= lu_d;
      pc_q      <= pc_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = req & ~done_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign dbg_state   = state_q;
  assign trace_valid = done_q & we_q & ~err_q;
  assign trace_pc    = pc_q;
  assign trace_addr  = addr_q;
  assign trace_data  = wr_data_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with LATENCY=2 and one with
// LATENCY=0, sharing clock and reset. Expected values are hand-computed.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        reset;

  // LATENCY=2 instance
  logic        req, we, lb, lh, sb, sh, lu;
  logic [31:0] addr, wdata, pc;
  logic        busy, done, err, trace_valid;
  logic [31:0] rdata, trace_pc, trace_addr, trace_data;
  logic [1:0]  dbg_state;

  // LATENCY=0 instance
  logic        req0, we0, lb0, lh0, sb0, sh0, lu0;
  logic [31:0] addr0, wdata0, pc0;
  logic        busy0, done0, err0, trace_valid0;
  logic [31:0] rdata0, trace_pc0, trace_addr0, trace_data0;
  logic [1:0]  dbg_state0;

  dmem_resp #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(2), .ADDR_SIZE(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lb(lb), .lh(lh), .sb(sb), .sh(sh), .lu(lu), .pc(pc),
    .busy(busy), .done(done), .rdata(rdata), .err(err), .dbg_state(dbg_state),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data)
  );

  dmem_resp #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(0), .ADDR_SIZE(32)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .lb(lb0), .lh(lh0), .sb(sb0), .sh(sh0), .lu(lu0), .pc(pc0),
    .busy(busy0), .done(done0), .rdata(rdata0), .err(err0), .dbg_state(dbg_state0),
    .trace_valid(trace_valid0), .trace_pc(trace_pc0), .trace_addr(trace_addr0),
    .trace_data(trace_data0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- store trace ----------------
  always @(negedge clk) begin
    if (trace_valid)  $display("trace L2 pc=%08h addr=%08h data=%08h", trace_pc, trace_addr, trace_data);
    if (trace_valid0) $display("trace L0 pc=%08h addr=%08h data=%08h", trace_pc0, trace_addr0, trace_data0);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_ctr   = 32'h0000_1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // Issues one request, waits (bounded) for done, returns latency in edges,
  // number of busy-high samples, and the completion outputs.
  task automatic mem_op(input bit use0, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic b_, input logic h_,
                        input logic u, output int lat, output int busy_n,
                        output logic [31:0] rd, output logic e,
                        output logic trv, output logic [31:0] trd);
    logic got_done, got_busy;
    @(negedge clk);
    pc_ctr += 4;
    if (use0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; pc0 = pc_ctr;
      lb0 = ~w & b_; lh0 = ~w & h_; sb0 = w & b_; sh0 = w & h_; lu0 = u;
    end else begin
      req = 1'b1; we = w; addr = a; wdata = d; pc = pc_ctr;
      lb = ~w & b_; lh = ~w & h_; sb = w & b_; sh = w & h_; lu = u;
    end
    #1;
    lat = -1; busy_n = 0; rd = '0; e = 1'b0; trv = 1'b0; trd = '0;
    for (int i = 1; i <= 20; i++) begin
      got_busy = use0 ? busy0 : busy;
      if (got_busy) busy_n++;
      @(posedge clk); #1;
      got_done = use0 ? done0 : done;
      if (got_done) begin
        lat = i;
        got_busy = use0 ? busy0 : busy;
        if (got_busy) busy_n++;
        rd  = use0 ? rdata0 : rdata;
        e   = use0 ? err0 : err;
        trv = use0 ? trace_valid0 : trace_valid;
        trd = use0 ? trace_data0 : trace_data;
        break;
      end
    end
    if (use0) req0 = 1'b0; else req = 1'b0;
    @(posedge clk); #1;
    got_done = use0 ? done0 : done;
    check("done_one_cycle", {31'd0, got_done}, 32'd0);
  endtask

  int          lat, bn;
  logic [31:0] rd, trd;
  logic        e, trv;

  task automatic load_chk(input string tag, input bit use0, input logic [31:0] a,
                          input logic b_, input logic h_, input logic u,
                          input logic [31:0] exp_v);
    logic [31:0] exp_item;
    exp_q.push_back(exp_v);
    mem_op(use0, 1'b0, a, 32'h0, b_, h_, u, lat, bn, rd, e, trv, trd);
    exp_item = exp_q.pop_front();
    check(tag, rd, exp_item);
    check({tag, "_err"}, {31'd0, e}, 32'd0);
  endtask

  logic done_seen;

  initial begin
    reset = 1'b1;
    req = 0; we = 0; lb = 0; lh = 0; sb = 0; sh = 0; lu = 0; addr = 0; wdata = 0; pc = 0;
    req0 = 0; we0 = 0; lb0 = 0; lh0 = 0; sb0 = 0; sh0 = 0; lu0 = 0; addr0 = 0; wdata0 = 0; pc0 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // word store then word load, latency 2
    mem_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, lat, bn, rd, e, trv, trd);
    check("sw_latency", lat, 3);
    check("sw_busy_cycles", bn, 3);
    check("sw_err", {31'd0, e}, 32'd0);
    check("sw_trace_valid", {31'd0, trv}, 32'd1);
    check("sw_trace_data", trd, 32'hDEADBEEF);
    mem_op(0, 1'b0, 32'h10, 32'h0, 0, 0, 0, lat, bn, rd, e, trv, trd);
    check("lw_latency", lat, 3);
    check("lw_busy_cycles", bn, 3);
    check("lw_rdata", rd, 32'hDEADBEEF);

    // sub-word loads
    load_chk("lb_13",  0, 32'h13, 1, 0, 0, 32'hFFFFFFDE);
    load_chk("lbu_13", 0, 32'h13, 1, 0, 1, 32'h000000DE);
    load_chk("lh_12",  0, 32'h12, 0, 1, 0, 32'hFFFFDEAD);
    load_chk("lb_10",  0, 32'h10, 1, 0, 0, 32'hFFFFFFEF);

    // sub-word stores
    mem_op(0, 1'b1, 32'h11, 32'hFFFFFF55, 1, 0, 0, lat, bn, rd, e, trv, trd);
    check("sb_trace_data", trd, 32'hDEAD55EF);
    load_chk("lw_after_sb", 0, 32'h10, 0, 0, 0, 32'hDEAD55EF);
    mem_op(0, 1'b1, 32'h12, 32'hABCD1234, 0, 1, 0, lat, bn, rd, e, trv, trd);
    load_chk("lw_after_sh", 0, 32'h10, 0, 0, 0, 32'h123455EF);
    load_chk("lhu_10", 0, 32'h10, 0, 1, 1, 32'h000055EF);
    // byte flags win over half flags
    load_chk("lb_over_lh", 0, 32'h11, 1, 1, 1, 32'h00000055);

    // misaligned half load
    mem_op(0, 1'b0, 32'h11, 32'h0, 0, 1, 0, lat, bn, rd, e, trv, trd);
    check("lh_mis_err", {31'd0, e}, 32'd1);
    check("lh_mis_rdata", rd, 32'h0);
    // misaligned word store: no write, no trace
    mem_op(0, 1'b1, 32'h12, 32'hFFFFFFFF, 0, 0, 0, lat, bn, rd, e, trv, trd);
    check("sw_mis_err", {31'd0, e}, 32'd1);
    check("sw_mis_trace", {31'd0, trv}, 32'd0);
    load_chk("lw_after_mis", 0, 32'h10, 0, 0, 0, 32'h123455EF);

    // wrap-around: byte address 4*1024+8 aliases word 2
    mem_op(0, 1'b1, 32'h1008, 32'hCAFEF00D, 0, 0, 0, lat, bn, rd, e, trv, trd);
    load_chk("wrap_lw_8", 0, 32'h8, 0, 0, 0, 32'hCAFEF00D);

    // reset during WAIT of a store
    mem_op(0, 1'b1, 32'h20, 32'h11223344, 0, 0, 0, lat, bn, rd, e, trv, trd);
    load_chk("lw_20_pre", 0, 32'h20, 0, 0, 0, 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAAAAAA;
    lb = 0; lh = 0; sb = 0; sh = 0; lu = 0;
    @(posedge clk); #1;
    check("rst_mid_in_wait", {30'd0, dbg_state}, 32'd1);
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
      if (i == 1) reset = 1'b0;
    end
    check("rst_mid_no_done", {31'd0, done_seen}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_err",   {31'd0, err}, 32'd0);
    check("rst_mid_busy",  {31'd0, busy}, 32'd0);
    check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    load_chk("lw_20_post", 0, 32'h20, 0, 0, 0, 32'h11223344);

    // LATENCY=0 instance
    mem_op(1, 1'b1, 32'h4, 32'h5A5A5A5A, 0, 0, 0, lat, bn, rd, e, trv, trd);
    check("l0_sw_latency", lat, 1);
    check("l0_sw_busy_cycles", bn, 1);
    mem_op(1, 1'b0, 32'h4, 32'h0, 0, 0, 0, lat, bn, rd, e, trv, trd);
    check("l0_lw_latency", lat, 1);
    check("l0_lw_rdata", rd, 32'h5A5A5A5A);
    load_chk("l0_lh_6", 1, 32'h6, 0, 1, 0, 32'h00005A5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
